// File: rtl/matvec_sequencer.sv
// Matrix-vector sequencer around a combinational dot_product core: loads a column and a
// row-major matrix over a valid/ready stream, then captures and streams one result per row.
module matvec_sequencer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned VECTOR_SIZE   = 4,
  parameter int unsigned NUM_ROWS      = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  localparam int unsigned IdxW         = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [2:0]                             round_mode_in,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] dp_row,
  output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] dp_col,
  output logic [2:0]                             dp_round_mode,
  input  logic [DATA_WIDTH-1:0]                  dp_result,
  input  logic [4:0]                             dp_exceptions,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic [4:0]                             out_exceptions,
  output logic [IdxW-1:0]                        out_index,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done,
  output logic [4:0]                             sticky_exceptions
);

  localparam int unsigned ElemW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam int unsigned SegW  = $clog2(NUM_ROWS + 1);
  localparam int unsigned SetW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [ElemW-1:0] ElemLast   = ElemW'(VECTOR_SIZE - 1);
  localparam logic [SegW-1:0]  SegLast    = SegW'(NUM_ROWS);
  localparam logic [SetW-1:0]  SettleInit = SetW'(SETTLE_CYCLES - 1);
  localparam logic [IdxW-1:0]  IdxLast    = IdxW'(NUM_ROWS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StEmit} state_e;

  state_e                 state_q, state_d;
  // Load position: segment 0 is the column, segments 1..NUM_ROWS are matrix rows.
  logic [SegW-1:0]        ld_seg_q, ld_seg_d;
  logic [ElemW-1:0]       ld_elem_q, ld_elem_d;
  logic [SetW-1:0]        settle_q, settle_d;
  logic [IdxW-1:0]        row_idx_q, row_idx_d;
  logic [2:0]             rm_q, rm_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [4:0]             out_exc_q, out_exc_d;
  logic [IdxW-1:0]        out_index_q, out_index_d;
  logic                   out_last_q, out_last_d;
  logic                   done_q, done_d;
  logic [4:0]             sticky_q, sticky_d;
  logic                   ld_fire;

  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] col_q;
  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] mat_q [NUM_ROWS];

  always_comb begin
    state_d     = state_q;
    ld_seg_d    = ld_seg_q;
    ld_elem_d   = ld_elem_q;
    settle_d    = settle_q;
    row_idx_d   = row_idx_q;
    rm_d        = rm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_exc_d   = out_exc_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    sticky_d    = sticky_q;
    ld_fire     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rm_d      = round_mode_in;
          sticky_d  = '0;
          ld_seg_d  = '0;
          ld_elem_d = '0;
          row_idx_d = '0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        if (in_valid) begin
          ld_fire = 1'b1;
          if (ld_elem_q == ElemLast) begin
            ld_elem_d = '0;
            if (ld_seg_q == SegLast) begin
              ld_seg_d = '0;
              settle_d = SettleInit;
              state_d  = StWait;
            end else begin
              ld_seg_d = ld_seg_q + 1'b1;
            end
          end else begin
            ld_elem_d = ld_elem_q + 1'b1;
          end
        end
      end
      StWait: begin
        if (settle_q == '0) begin
          out_data_d  = dp_result;
          out_exc_d   = dp_exceptions;
          sticky_d    = sticky_q | dp_exceptions;
          out_index_d = row_idx_q;
          out_last_d  = (row_idx_q == IdxLast);
          out_valid_d = 1'b1;
          state_d     = StEmit;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      StEmit: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
            settle_d  = SettleInit;
            state_d   = StWait;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ld_seg_q    <= '0;
      ld_elem_q   <= '0;
      settle_q    <= '0;
      row_idx_q   <= '0;
      rm_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_exc_q   <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      sticky_q    <= '0;
    end else begin
      state_q     <= state_d;
      ld_seg_q    <= ld_seg_d;
      ld_elem_q   <= ld_elem_d;
      settle_q    <= settle_d;
      row_idx_q   <= row_idx_d;
      rm_q        <= rm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_exc_q   <= out_exc_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      sticky_q    <= sticky_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        mat_q[r] <= '0;
      end
    end else if (ld_fire) begin
      for (int e = 0; e < VECTOR_SIZE; e++) begin
        if (ld_seg_q == '0 && ld_elem_q == ElemW'(e)) begin
          col_q[e] <= in_data;
        end
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int e = 0; e < VECTOR_SIZE; e++) begin
          if (ld_seg_q == SegW'(r + 1) && ld_elem_q == ElemW'(e)) begin
            mat_q[r][e] <= in_data;
          end
        end
      end
    end
  end

  // Decoded row select keeps the mux in range for non-power-of-two NUM_ROWS.
  always_comb begin
    dp_row = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_idx_q == IdxW'(r)) begin
        dp_row = mat_q[r];
      end
    end
  end

  assign dp_col            = col_q;
  assign dp_round_mode     = rm_q;
  assign in_ready          = (state_q == StLoad);
  assign busy              = (state_q != StIdle);
  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_exceptions    = out_exc_q;
  assign out_index         = out_index_q;
  assign out_last          = out_last_q;
  assign done              = done_q;
  assign sticky_exceptions = sticky_q;

endmodule

// File: tb/tb_matvec_sequencer.sv
// Scoreboard bench for matvec_sequencer: two instances (settle 1 and 3) share stimulus,
// a behavioural stand-in for dot_product drives dp_result/dp_exceptions.
module tb_matvec_sequencer;

  localparam int DW = 32;
  localparam int VS = 4;
  localparam int NR = 4;
  localparam int IW = 2;

  typedef logic [VS-1:0][DW-1:0] vec_t;
  typedef vec_t mat_t [NR];
  typedef struct packed {
    logic [DW-1:0] data;
    logic [4:0]    exc;
    logic [IW-1:0] idx;
    logic          last;
    logic [2:0]    rm;
  } exp_t;

  logic          clk, rst_n, start, in_valid, out_ready;
  logic [2:0]    rm;
  logic [DW-1:0] in_data;
  int            sel;

  logic          start_g [2];
  logic          in_valid_g [2];
  logic          in_ready_w [2];
  vec_t          dp_row_w [2];
  vec_t          dp_col_w [2];
  logic [2:0]    dp_rm_w [2];
  logic [DW-1:0] dp_res_w [2];
  logic [4:0]    dp_exc_w [2];
  logic          out_valid_w [2];
  logic [DW-1:0] out_data_w [2];
  logic [4:0]    out_exc_w [2];
  logic [IW-1:0] out_idx_w [2];
  logic          out_last_w [2];
  logic          busy_w [2];
  logic          done_w [2];
  logic [4:0]    sticky_w [2];

  int   n_tests, n_fail, cyc;
  exp_t sb[$];
  exp_t mon_e;
  logic [4:0] exp_sticky;

  // Stand-in datapath: position-sensitive so swapped or misplaced elements show up.
  function automatic logic [36:0] stub(input vec_t r, input vec_t c);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < VS; i++) s = s + (r[i] ^ c[i]) * 32'(i + 1);
    return {s, s[31:27] ^ r[0][4:0]};
  endfunction

  function automatic int settle_of(input int d);
    return (d != 0) ? 3 : 1;
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      start_g[d]                 = start && (sel == d);
      in_valid_g[d]              = in_valid && (sel == d);
      {dp_res_w[d], dp_exc_w[d]} = stub(dp_row_w[d], dp_col_w[d]);
    end
  end

  matvec_sequencer #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .NUM_ROWS(NR), .SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_g[0]), .round_mode_in(rm),
    .in_valid(in_valid_g[0]), .in_ready(in_ready_w[0]), .in_data(in_data),
    .dp_row(dp_row_w[0]), .dp_col(dp_col_w[0]), .dp_round_mode(dp_rm_w[0]),
    .dp_result(dp_res_w[0]), .dp_exceptions(dp_exc_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
    .out_exceptions(out_exc_w[0]), .out_index(out_idx_w[0]), .out_last(out_last_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .sticky_exceptions(sticky_w[0])
  );

  matvec_sequencer #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .NUM_ROWS(NR), .SETTLE_CYCLES(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_g[1]), .round_mode_in(rm),
    .in_valid(in_valid_g[1]), .in_ready(in_ready_w[1]), .in_data(in_data),
    .dp_row(dp_row_w[1]), .dp_col(dp_col_w[1]), .dp_round_mode(dp_rm_w[1]),
    .dp_result(dp_res_w[1]), .dp_exceptions(dp_exc_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
    .out_exceptions(out_exc_w[1]), .out_index(out_idx_w[1]), .out_last(out_last_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .sticky_exceptions(sticky_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag, input int d);
    check({tag, "_ctrl"}, 64'({in_ready_w[d], out_valid_w[d], out_data_w[d], out_exc_w[d],
                               out_idx_w[d], out_last_w[d], busy_w[d], done_w[d],
                               sticky_w[d], dp_rm_w[d]}), 64'd0);
    check({tag, "_store"}, 64'((|dp_row_w[d]) | (|dp_col_w[d])), 64'd0);
  endtask

  // Monitor: everything sampled on the falling edge, away from the active edge.
  int         ld_words, last_ld;
  bit         lat_pend, hold_pend, exp_done;
  logic [39:0] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      ld_words  = 0;
      lat_pend  = 0;
      hold_pend = 0;
      exp_done  = 0;
    end else begin
      if (in_valid && in_ready_w[sel]) begin
        ld_words++;
        if (ld_words == VS * (NR + 1)) begin
          ld_words = 0;
          last_ld  = cyc;
          lat_pend = 1;
        end
      end
      if (lat_pend && out_valid_w[sel]) begin
        check("first_valid_latency", 64'(cyc - last_ld), 64'(settle_of(sel) + 1));
        lat_pend = 0;
      end
      if (hold_pend) begin
        check("hold_valid", 64'(out_valid_w[sel]), 64'd1);
        check("hold_fields", 64'({out_data_w[sel], out_exc_w[sel], out_idx_w[sel],
                                  out_last_w[sel]}), 64'(held));
      end
      hold_pend = out_valid_w[sel] && !out_ready;
      held      = {out_data_w[sel], out_exc_w[sel], out_idx_w[sel], out_last_w[sel]};
      check("done_pulse", 64'(done_w[sel]), 64'(exp_done));
      if (done_w[sel]) check("sticky", 64'(sticky_w[sel]), 64'(exp_sticky));
      exp_done = 0;
      if (out_valid_w[sel] && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", 64'(out_data_w[sel]), 64'(mon_e.data));
          check("out_exc", 64'(out_exc_w[sel]), 64'(mon_e.exc));
          check("out_index", 64'(out_idx_w[sel]), 64'(mon_e.idx));
          check("out_last", 64'(out_last_w[sel]), 64'(mon_e.last));
          check("dp_round_mode", 64'(dp_rm_w[sel]), 64'(mon_e.rm));
          exp_done = mon_e.last;
        end
      end
    end
  end

  task automatic run_job(input vec_t col, input mat_t mat, input logic [2:0] mode,
                         input bit stall, input bit bp, input bit storm, input bit abort);
    logic [36:0] r;
    logic [3:0]  pat;
    bit          ok, seen;
    pat        = 4'b1001;
    exp_sticky = '0;
    for (int i = 0; i < NR; i++) begin
      r = stub(mat[i], col);
      exp_sticky |= r[4:0];
      sb.push_back('{data: r[36:5], exc: r[4:0], idx: IW'(i), last: (i == NR - 1), rm: mode});
    end
    out_ready = 1'b1;
    start     = 1'b1;
    rm        = mode;
    @(posedge clk); #1;
    if (!storm) start = 1'b0;
    rm = ~mode;
    check("sticky_clear_on_start", 64'(sticky_w[sel]), 64'd0);
    for (int k = 0; k < VS * (NR + 1); k++) begin
      if (stall) begin
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin in_valid = 1'b0; @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = (k < VS) ? col[k] : mat[(k - VS) / VS][(k - VS) % VS];
      ok = 0;
      for (int t = 0; t < 10 && !ok; t++) begin
        @(negedge clk);
        ok = in_ready_w[sel];
        @(posedge clk); #1;
      end
      if (!ok) begin
        check("load_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    if (abort) begin
      rst_n = 1'b0;
      #1;
      check_reset("abort", sel);
      sb.delete();
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("abort_stays_idle", 64'(busy_w[sel]), 64'd0);
      return;
    end
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done_w[sel]) begin seen = 1; break; end
      if (bp) out_ready = pat[i % 4];
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check("job_done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    check("idle_after_job", 64'(busy_w[sel]), 64'd0);
    check("results_drained", 64'(sb.size()), 64'd0);
  endtask

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < NR; i++)
      for (int e = 0; e < VS; e++) m[i][e] = $urandom;
    return m;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t col;
    mat_t m;
    n_tests = 0; n_fail = 0; cyc = 0; sel = 0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rm = '0; in_data = '0;
    #1;
    check_reset("reset_s1", 0);
    check_reset("reset_s3", 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Identity matrix.
    col = {32'hbf800000, 32'h3fc00000, 32'h40000000, 32'h3f800000};
    for (int i = 0; i < NR; i++)
      for (int e = 0; e < VS; e++) m[i][e] = (i == e) ? 32'h3f800000 : 32'h0;
    run_job(col, m, 3'b000, 0, 0, 0, 0);

    // Mixed signs, round mode 000, then a different mode to confirm the latch.
    col = {32'h3fc00000, 32'hc0000000, 32'h3f800000, 32'h40400000};
    m = rand_mat();
    m[0] = {32'hbf800000, 32'h3fc00000, 32'h40000000, 32'h3f800000};
    run_job(col, m, 3'b000, 0, 0, 0, 0);
    run_job(col, rand_mat(), 3'b011, 0, 0, 0, 0);

    // Back-pressure on the result stream.
    col = {$urandom, $urandom, $urandom, $urandom};
    run_job(col, rand_mat(), 3'b001, 0, 1, 0, 0);

    // Load stalls, settle 1 then settle 3.
    col = {$urandom, $urandom, $urandom, $urandom};
    run_job(col, rand_mat(), 3'b010, 1, 0, 0, 0);
    sel = 1;
    run_job(col, rand_mat(), 3'b100, 1, 0, 0, 0);
    run_job(col, rand_mat(), 3'b000, 1, 1, 0, 0);

    // Large magnitude in row 1; the following job must start with sticky cleared.
    sel = 0;
    col = {32'h0, 32'h0, 32'h0, 32'h40000000};
    m = rand_mat();
    m[1] = {32'h0, 32'h0, 32'h0, 32'h7f7fffff};
    run_job(col, m, 3'b000, 0, 0, 0, 0);
    run_job(col, rand_mat(), 3'b000, 0, 0, 0, 0);

    // start held high through load and emit, including the final handshake cycle.
    sel = 1;
    run_job(col, rand_mat(), 3'b010, 0, 1, 1, 0);
    sel = 0;
    run_job(col, rand_mat(), 3'b001, 1, 1, 1, 0);

    // Reset while in WAIT.
    sel = 1;
    run_job(col, rand_mat(), 3'b111, 0, 0, 0, 1);
    sel = 0;
    run_job(col, rand_mat(), 3'b110, 0, 0, 0, 1);
    run_job(col, rand_mat(), 3'b101, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
